// File: rtl/layer_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : layer_sequencer
// Description : Fully-connected layer sequencer. It addresses the input, weight
//               and bias RAMs, runs a signed MAC over each neuron, then applies
//               bias, rescale, ReLU and saturation before writing the result.
// Revision    : 1.0 - initial release
// ============================================================================
module layer_sequencer #(
    parameter int N_INPUTS  = 4,
    parameter int N_NEURONS = 4,
    parameter int DW        = 8,
    parameter int ACCW      = 20,
    parameter int SHIFT     = 4,
    localparam int XAW = (N_INPUTS > 1) ? $clog2(N_INPUTS) : 1,
    localparam int WAW = (N_INPUTS * N_NEURONS > 1) ? $clog2(N_INPUTS * N_NEURONS) : 1,
    localparam int NAW = (N_NEURONS > 1) ? $clog2(N_NEURONS) : 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 abort,
    output logic                 busy,
    output logic                 done,
    output logic [XAW-1:0]       x_addr,
    output logic [WAW-1:0]       w_addr,
    output logic [NAW-1:0]       b_addr,
    input  logic signed [DW-1:0] x_data,
    input  logic signed [DW-1:0] w_data,
    input  logic signed [DW-1:0] b_data,
    output logic                 y_we,
    output logic [NAW-1:0]       y_addr,
    output logic [DW-1:0]        y_data
);

    localparam logic [2:0] c_ST_IDLE  = 3'd0;
    localparam logic [2:0] c_ST_RUN   = 3'd1;
    localparam logic [2:0] c_ST_DRAIN = 3'd2;
    localparam logic [2:0] c_ST_ACT   = 3'd3;
    localparam logic [2:0] c_ST_DONE  = 3'd4;

    localparam logic [XAW-1:0]         c_I_LAST = XAW'(N_INPUTS - 1);
    localparam logic [NAW-1:0]         c_N_LAST = NAW'(N_NEURONS - 1);
    localparam logic [DW-1:0]          c_Y_SAT  = {1'b0, {(DW-1){1'b1}}};
    localparam logic signed [ACCW-1:0] c_Y_MAX  = {{(ACCW-DW){1'b0}}, c_Y_SAT};

    logic [2:0]             r_state;
    logic                   r_busy;
    logic                   r_done;
    logic [XAW-1:0]         r_i;
    logic [NAW-1:0]         r_n;
    logic [WAW-1:0]         r_w_addr;
    logic signed [ACCW-1:0] r_acc;
    logic                   r_mac_v;
    logic                   r_y_we;
    logic [NAW-1:0]         r_y_addr;
    logic [DW-1:0]          r_y_data;

    logic signed [2*DW-1:0] w_prod;
    logic signed [ACCW-1:0] w_prod_ext;
    logic signed [ACCW-1:0] w_acc_fin;
    logic signed [ACCW-1:0] w_bias_sh;
    logic signed [ACCW-1:0] w_sum;
    logic signed [ACCW-1:0] w_s;
    logic [DW-1:0]          w_y;

    assign w_prod     = x_data * w_data;
    assign w_prod_ext = {{(ACCW-2*DW){w_prod[2*DW-1]}}, w_prod};
    assign w_acc_fin  = r_mac_v ? (r_acc + w_prod_ext) : r_acc;
    assign w_bias_sh  = {{(ACCW-DW){b_data[DW-1]}}, b_data} <<< SHIFT;
    assign w_sum      = w_acc_fin + w_bias_sh;
    assign w_s        = w_sum >>> SHIFT;

    // The result is formed from the final accumulator value on the DRAIN edge
    // so that it is already registered while y_we is high in ACT.
    always_comb begin
        w_y = w_s[DW-1:0];
        if (w_s[ACCW-1]) begin
            w_y = '0;
        end else if (w_s > c_Y_MAX) begin
            w_y = c_Y_SAT;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state  <= c_ST_IDLE;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_i      <= '0;
            r_n      <= '0;
            r_w_addr <= '0;
            r_acc    <= '0;
            r_mac_v  <= 1'b0;
            r_y_we   <= 1'b0;
            r_y_addr <= '0;
            r_y_data <= '0;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (start) begin
                        r_state  <= c_ST_RUN;
                        r_busy   <= 1'b1;
                        r_i      <= '0;
                        r_n      <= '0;
                        r_w_addr <= '0;
                        r_acc    <= '0;
                        r_mac_v  <= 1'b0;
                    end
                end
                c_ST_RUN: begin
                    if (abort) begin
                        r_state <= c_ST_IDLE;
                        r_busy  <= 1'b0;
                        r_acc   <= '0;
                        r_mac_v <= 1'b0;
                        r_y_we  <= 1'b0;
                    end else begin
                        r_mac_v <= 1'b1;
                        r_acc   <= w_acc_fin;
                        if (r_i == c_I_LAST) begin
                            r_state <= c_ST_DRAIN;
                        end else begin
                            r_i      <= r_i + XAW'(1);
                            r_w_addr <= r_w_addr + WAW'(1);
                        end
                    end
                end
                c_ST_DRAIN: begin
                    if (abort) begin
                        r_state <= c_ST_IDLE;
                        r_busy  <= 1'b0;
                        r_acc   <= '0;
                        r_mac_v <= 1'b0;
                        r_y_we  <= 1'b0;
                    end else begin
                        r_acc    <= w_acc_fin;
                        r_mac_v  <= 1'b0;
                        r_y_we   <= 1'b1;
                        r_y_addr <= r_n;
                        r_y_data <= w_y;
                        r_state  <= c_ST_ACT;
                    end
                end
                c_ST_ACT: begin
                    r_y_we <= 1'b0;
                    if (abort) begin
                        r_state <= c_ST_IDLE;
                        r_busy  <= 1'b0;
                        r_acc   <= '0;
                        r_mac_v <= 1'b0;
                    end else if (r_n == c_N_LAST) begin
                        r_state <= c_ST_DONE;
                        r_done  <= 1'b1;
                    end else begin
                        r_n      <= r_n + NAW'(1);
                        r_i      <= '0;
                        r_w_addr <= r_w_addr + WAW'(1);
                        r_acc    <= '0;
                        r_state  <= c_ST_RUN;
                    end
                end
                c_ST_DONE: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= c_ST_IDLE;
                end
                default: begin
                    r_state <= c_ST_IDLE;
                end
            endcase
        end
    end

    assign busy   = r_busy;
    assign done   = r_done;
    assign x_addr = r_i;
    assign w_addr = r_w_addr;
    assign b_addr = r_n;
    assign y_we   = r_y_we;
    assign y_addr = r_y_addr;
    assign y_data = r_y_data;

endmodule
`default_nettype wire

// File: tb/tb_layer_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_layer_sequencer
// Description : Directed self-checking bench for layer_sequencer with
//               sync-read RAM models and a write/done monitor.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_layer_sequencer;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic              start = 1'b0;
    logic              abort = 1'b0;
    logic              busy, done, y_we;
    logic [1:0]        x_addr, b_addr, y_addr;
    logic [3:0]        w_addr;
    logic signed [7:0] x_data = '0, w_data = '0, b_data = '0;
    logic [7:0]        y_data;

    logic signed [7:0] x_mem [0:3];
    logic signed [7:0] w_mem [0:15];
    logic signed [7:0] b_mem [0:3];

    logic [7:0] y_res    [0:3];
    logic [1:0] b_at_we  [0:3];
    int         we_cnt   = 0;
    int         done_cnt = 0;
    int         tests    = 0;
    int         fails    = 0;

    layer_sequencer dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .abort  (abort),
        .busy   (busy),
        .done   (done),
        .x_addr (x_addr),
        .w_addr (w_addr),
        .b_addr (b_addr),
        .x_data (x_data),
        .w_data (w_data),
        .b_data (b_data),
        .y_we   (y_we),
        .y_addr (y_addr),
        .y_data (y_data)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        x_data <= x_mem[x_addr];
        w_data <= w_mem[w_addr];
        b_data <= b_mem[b_addr];
    end

    always @(posedge clk) begin
        if (y_we === 1'b1) begin
            we_cnt++;
            y_res[y_addr]   = y_data;
            b_at_we[y_addr] = b_addr;
        end
        if (done === 1'b1) done_cnt++;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, time=%0t", $time);
        $fatal(1, "watchdog");
    end

    task automatic fill_uniform(input logic signed [7:0] xv, input logic signed [7:0] wv,
                                input logic signed [7:0] bv);
        for (int k = 0; k < 4; k++) begin
            x_mem[k] = xv;
            b_mem[k] = bv;
        end
        for (int k = 0; k < 16; k++) w_mem[k] = wv;
    endtask

    task automatic clear_records();
        we_cnt   = 0;
        done_cnt = 0;
        for (int k = 0; k < 4; k++) begin
            y_res[k]   = 8'h55;
            b_at_we[k] = 'x;
        end
    endtask

    // Starts one pass from a negedge and returns the cycle in which done was seen
    // (-1 if it never came); leaves the bench at a negedge with the DUT idle.
    task automatic run_pass(output int done_cyc);
        clear_records();
        done_cyc = -1;
        start = 1'b1;
        for (int c = 1; c <= 100; c++) begin
            @(negedge clk);
            start = 1'b0;
            if (done === 1'b1) begin
                done_cyc = c;
                break;
            end
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        logic [20:0] obs;
        reset = 1'b0;
        repeat (3) @(negedge clk);
        obs = {busy, done, y_we, x_addr, w_addr, b_addr, y_addr, y_data};
        tests++;
        if (obs !== 21'd0) begin
            fails++;
            $display("FAIL reset_outputs: got %h, want 0", obs);
        end
        reset = 1'b1;
        repeat (2) @(negedge clk);
        tests++;
        if (busy !== 1'b0) begin
            fails++;
            $display("FAIL reset_idle_busy: got %b, want 0", busy);
        end
    endtask

    task automatic test_basic();
        int dc;
        fill_uniform(8'sd16, 8'sd16, 8'sd0);
        run_pass(dc);
        tests++;
        if (dc !== 25) begin
            fails++;
            $display("FAIL basic_done_cycle: got %0d, want 25", dc);
        end
        for (int k = 0; k < 4; k++) begin
            tests++;
            if (y_res[k] !== 8'd64) begin
                fails++;
                $display("FAIL basic_y[%0d]: got %0d, want 64", k, y_res[k]);
            end
        end
        tests++;
        if (we_cnt !== 4 || done_cnt !== 1) begin
            fails++;
            $display("FAIL basic_counts: we=%0d done=%0d, want 4/1", we_cnt, done_cnt);
        end
    endtask

    task automatic test_relu();
        int dc;
        fill_uniform(8'sd16, -8'sd16, 8'sd0);
        run_pass(dc);
        for (int k = 0; k < 4; k++) begin
            tests++;
            if (y_res[k] !== 8'd0) begin
                fails++;
                $display("FAIL relu_y[%0d]: got %0d, want 0", k, y_res[k]);
            end
        end
    endtask

    task automatic test_saturate();
        int dc;
        fill_uniform(8'sd127, 8'sd127, 8'sd0);
        run_pass(dc);
        for (int k = 0; k < 4; k++) begin
            tests++;
            if (y_res[k] !== 8'd127) begin
                fails++;
                $display("FAIL sat_y[%0d]: got %0d, want 127", k, y_res[k]);
            end
        end
    endtask

    task automatic test_bias();
        int dc;
        fill_uniform(8'sd16, 8'sd16, -8'sd32);
        run_pass(dc);
        for (int k = 0; k < 4; k++) begin
            tests++;
            if (y_res[k] !== 8'd32 || b_at_we[k] !== 2'(k)) begin
                fails++;
                $display("FAIL bias_y[%0d]: got y=%0d b_addr=%0d, want y=32 b_addr=%0d",
                         k, y_res[k], b_at_we[k], k);
            end
        end
    endtask

    // Distinct weights per neuron and per-neuron bias expose addressing errors.
    task automatic test_mixed();
        int dc;
        logic [7:0] exp_y [0:3];
        x_mem[0] = 8'sd16; x_mem[1] = 8'sd32; x_mem[2] = 8'sd0; x_mem[3] = 8'sd16;
        b_mem[0] = 8'sd0;  b_mem[1] = 8'sd16; b_mem[2] = -8'sd16; b_mem[3] = 8'sd8;
        for (int k = 0; k < 16; k++) w_mem[k] = 8'sd0;
        w_mem[0]  = 8'sd16;
        w_mem[5]  = 8'sd16;
        w_mem[11] = 8'sd48;
        for (int k = 12; k < 16; k++) w_mem[k] = 8'sd16;
        exp_y[0] = 8'd16; exp_y[1] = 8'd48; exp_y[2] = 8'd32; exp_y[3] = 8'd72;
        run_pass(dc);
        for (int k = 0; k < 4; k++) begin
            tests++;
            if (y_res[k] !== exp_y[k]) begin
                fails++;
                $display("FAIL mixed_y[%0d]: got %0d, want %0d", k, y_res[k], exp_y[k]);
            end
        end
    endtask

    task automatic test_abort();
        int dc;
        fill_uniform(8'sd16, 8'sd16, 8'sd0);
        clear_records();
        start = 1'b1;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            start = 1'b0;
            if (c == 14) abort = 1'b1;
            if (c == 15) begin
                abort = 1'b0;
                tests++;
                if (busy !== 1'b0) begin
                    fails++;
                    $display("FAIL abort_busy: got %b, want 0", busy);
                end
            end
        end
        tests++;
        if (we_cnt !== 2 || done_cnt !== 0 || y_res[2] !== 8'h55 || y_res[3] !== 8'h55) begin
            fails++;
            $display("FAIL abort_writes: we=%0d done=%0d y2=%h y3=%h, want 2/0/55/55",
                     we_cnt, done_cnt, y_res[2], y_res[3]);
        end
        run_pass(dc);
        tests++;
        if (dc !== 25 || we_cnt !== 4) begin
            fails++;
            $display("FAIL abort_restart: done_cyc=%0d we=%0d, want 25/4", dc, we_cnt);
        end
        for (int k = 0; k < 4; k++) begin
            tests++;
            if (y_res[k] !== 8'd64) begin
                fails++;
                $display("FAIL abort_restart_y[%0d]: got %0d, want 64", k, y_res[k]);
            end
        end
    endtask

    task automatic test_reset_midpass();
        logic [20:0] obs;
        fill_uniform(8'sd16, 8'sd16, 8'sd0);
        clear_records();
        start = 1'b1;
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk);
            start = 1'b0;
        end
        #2 reset = 1'b0;
        #1 obs = {busy, done, y_we, x_addr, w_addr, b_addr, y_addr, y_data};
        tests++;
        if (obs !== 21'd0) begin
            fails++;
            $display("FAIL reset_midpass: got %h, want 0", obs);
        end
        @(negedge clk);
        reset = 1'b1;
        repeat (5) @(negedge clk);
        tests++;
        if (busy !== 1'b0 || done_cnt !== 0) begin
            fails++;
            $display("FAIL reset_midpass_idle: busy=%b done_cnt=%0d, want 0/0", busy, done_cnt);
        end
    endtask

    task automatic test_start_ignored();
        int dc;
        fill_uniform(8'sd16, 8'sd16, 8'sd0);
        clear_records();
        dc = -1;
        start = 1'b1;
        for (int c = 1; c <= 60; c++) begin
            @(negedge clk);
            start = (c == 5 || c == 12 || c == 25);
            if (done === 1'b1 && dc < 0) dc = c;
        end
        start = 1'b0;
        tests++;
        if (dc !== 25 || done_cnt !== 1 || we_cnt !== 4 || busy !== 1'b0) begin
            fails++;
            $display("FAIL start_ignored: done_cyc=%0d done=%0d we=%0d busy=%b, want 25/1/4/0",
                     dc, done_cnt, we_cnt, busy);
        end
    endtask

    task automatic test_back_to_back();
        int dcs [0:2];
        int nd;
        fill_uniform(8'sd16, 8'sd16, -8'sd32);
        clear_records();
        for (int k = 0; k < 3; k++) dcs[k] = -1;
        nd = 0;
        start = 1'b1;
        for (int c = 1; c <= 120; c++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                dcs[nd] = c;
                nd++;
                if (nd == 3) break;
            end
        end
        start = 1'b0;
        tests++;
        if (dcs[0] !== 25 || dcs[1] !== 51 || dcs[2] !== 77) begin
            fails++;
            $display("FAIL b2b_done_cycles: got %0d/%0d/%0d, want 25/51/77",
                     dcs[0], dcs[1], dcs[2]);
        end
        repeat (4) @(negedge clk);
        tests++;
        if (busy !== 1'b0 || we_cnt !== 12 || y_res[3] !== 8'd32) begin
            fails++;
            $display("FAIL b2b_end: busy=%b we=%0d y3=%0d, want 0/12/32", busy, we_cnt, y_res[3]);
        end
    endtask

    initial begin
        fill_uniform(8'sd0, 8'sd0, 8'sd0);
        test_reset();
        test_basic();
        test_relu();
        test_saturate();
        test_bias();
        test_mixed();
        test_abort();
        test_reset_midpass();
        test_start_ignored();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
